// File: rtl/control_subcmd_wrport_arbiter.sv
// control_subcmd_wrport_arbiter
// Shares the single frame-buffer write port between NUM_REQ subcommand write
// engines. One engine is granted at a time in round-robin order. The grantee's
// enable is gated by mem_ready, and its write stream is forwarded through one
// register stage. Each command is closed with a one-cycle ack pulse. A watchdog
// aborts an engine whose strobe stops toggling.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req               per-engine request level, held until acked
//   mem_ready         write port can accept a byte this cycle
//   eng_row/column/pixel/data/we/strobe/done  packed per-engine write streams
//   eng_enable        grant & mem_ready (combinational, one-hot or zero)
//   eng_ack           one-cycle pulse closing the granted command
//   row/column/pixel/data_out/ram_write_enable  forwarded write stream
//   ram_access_start  arbiter-owned toggle strobe
//   busy              an engine is granted (GRANT or ACK)
//   grant_id          index of the current or last grantee
//   timeout_err       sticky watchdog abort flag
module control_subcmd_wrport_arbiter #(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned PIXEL_WIDTH     = 64,
  parameter int unsigned PIXEL_HEIGHT    = 32,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned CW  = $clog2(PIXEL_WIDTH),
  localparam int unsigned RW  = $clog2(PIXEL_HEIGHT),
  localparam int unsigned PSW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  localparam int unsigned GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic                   mem_ready,
  input  logic [NUM_REQ*RW-1:0]  eng_row,
  input  logic [NUM_REQ*CW-1:0]  eng_column,
  input  logic [NUM_REQ*PSW-1:0] eng_pixel,
  input  logic [NUM_REQ*8-1:0]   eng_data,
  input  logic [NUM_REQ-1:0]     eng_we,
  input  logic [NUM_REQ-1:0]     eng_strobe,
  input  logic [NUM_REQ-1:0]     eng_done,
  output logic [NUM_REQ-1:0]     eng_enable,
  output logic [NUM_REQ-1:0]     eng_ack,
  output logic [RW-1:0]          row,
  output logic [CW-1:0]          column,
  output logic [PSW-1:0]         pixel,
  output logic [7:0]             data_out,
  output logic                   ram_write_enable,
  output logic                   ram_access_start,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output logic                   timeout_err
);

  localparam int unsigned IW  = GW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t         state;
  logic [GW-1:0]  rr_ptr;
  logic           last_strobe;
  logic [WDW-1:0] wd_cnt;

  // Round-robin pick: first set req bit at or after rr_ptr, wrapping explicitly
  // because NUM_REQ need not be a power of two.
  logic          pick_valid;
  logic [GW-1:0] pick_id;
  logic [IW-1:0] scan_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      scan_idx = IW'(rr_ptr) + IW'(k);
      if (scan_idx >= IW'(NUM_REQ)) begin
        scan_idx = scan_idx - IW'(NUM_REQ);
      end
      if (!pick_valid && req[scan_idx[GW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = scan_idx[GW-1:0];
      end
    end
  end

  // Select the granted engine's lane.
  logic [RW-1:0]  sel_row;
  logic [CW-1:0]  sel_column;
  logic [PSW-1:0] sel_pixel;
  logic [7:0]     sel_data;
  logic           sel_we;
  logic           sel_strobe;
  logic           sel_done;
  logic           sel_req;

  always_comb begin
    sel_row    = '0;
    sel_column = '0;
    sel_pixel  = '0;
    sel_data   = '0;
    sel_we     = 1'b0;
    sel_strobe = 1'b0;
    sel_done   = 1'b0;
    sel_req    = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == GW'(i)) begin
        sel_row    = eng_row[i*RW +: RW];
        sel_column = eng_column[i*CW +: CW];
        sel_pixel  = eng_pixel[i*PSW +: PSW];
        sel_data   = eng_data[i*8 +: 8];
        sel_we     = eng_we[i];
        sel_strobe = eng_strobe[i];
        sel_done   = eng_done[i];
        sel_req    = req[i];
      end
    end
  end

  // Enable follows mem_ready in the same cycle so a stalled port freezes the engine.
  always_comb begin
    eng_enable = '0;
    if (state == GRANT && mem_ready) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        eng_enable[i] = (grant_id == GW'(i));
      end
    end
  end

  logic strobe_edge;
  logic rel_drop;
  logic rel_done;
  logic rel_tmo;

  assign strobe_edge = (sel_strobe != last_strobe);
  assign rel_drop    = !sel_req;
  // done alone is not enough: the engine must also have dropped we.
  assign rel_done    = sel_done && !sel_we;
  assign rel_tmo     = !strobe_edge && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  // Arbiter state, forwarding register, strobe regeneration and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      last_strobe      <= 1'b0;
      wd_cnt           <= '0;
      eng_ack          <= '0;
      row              <= '0;
      column           <= '0;
      pixel            <= '0;
      data_out         <= '0;
      ram_write_enable <= 1'b0;
      ram_access_start <= 1'b0;
      busy             <= 1'b0;
      grant_id         <= '0;
      timeout_err      <= 1'b0;
    end else begin
      eng_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id    <= pick_id;
            // Adopt the engine's current strobe phase so the grant itself never toggles.
            last_strobe <= eng_strobe[pick_id];
            busy        <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          row              <= sel_row;
          column           <= sel_column;
          pixel            <= sel_pixel;
          data_out         <= sel_data;
          ram_write_enable <= sel_we;
          if (strobe_edge) begin
            ram_access_start <= ~ram_access_start;
            last_strobe      <= sel_strobe;
            wd_cnt           <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
          if (rel_drop || rel_done || rel_tmo) begin
            state             <= ACK;
            eng_ack[grant_id] <= 1'b1;
            ram_write_enable  <= 1'b0;
            if (!rel_drop && !rel_done) begin
              timeout_err <= 1'b1;
            end
          end
        end
        ACK: begin
          rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          wd_cnt <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_subcmd_wrport_arbiter.sv
// Testbench for control_subcmd_wrport_arbiter: behavioural engine models feed
// a write scoreboard and a grant-order scoreboard; table vectors cover single
// commands, hand-written sequences cover contention, stall, watchdog and reset.
module tb_control_subcmd_wrport_arbiter;

  localparam int NR  = 3;
  localparam int RW  = 5;
  localparam int CW  = 6;
  localparam int PSW = 1;
  localparam int GW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic              mem_ready;
  logic [NR*RW-1:0]  eng_row;
  logic [NR*CW-1:0]  eng_column;
  logic [NR*PSW-1:0] eng_pixel;
  logic [NR*8-1:0]   eng_data;
  logic [NR-1:0]     eng_we;
  logic [NR-1:0]     eng_strobe;
  logic [NR-1:0]     eng_done;
  logic [NR-1:0]     eng_enable;
  logic [NR-1:0]     eng_ack;
  logic [RW-1:0]     row;
  logic [CW-1:0]     column;
  logic [PSW-1:0]    pixel;
  logic [7:0]        data_out;
  logic              ram_write_enable;
  logic              ram_access_start;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic              timeout_err;

  always #5 clk = ~clk;

  control_subcmd_wrport_arbiter #(
    .NUM_REQ(3), .PIXEL_WIDTH(64), .PIXEL_HEIGHT(32),
    .BYTES_PER_PIXEL(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .mem_ready(mem_ready),
    .eng_row(eng_row), .eng_column(eng_column), .eng_pixel(eng_pixel),
    .eng_data(eng_data), .eng_we(eng_we), .eng_strobe(eng_strobe),
    .eng_done(eng_done), .eng_enable(eng_enable), .eng_ack(eng_ack),
    .row(row), .column(column), .pixel(pixel), .data_out(data_out),
    .ram_write_enable(ram_write_enable), .ram_access_start(ram_access_start),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [4:0] row;
    logic [5:0] col;
    logic       pix;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int id;
    int nbytes;
    int r;
    int c;
    int d;
    bit early;
    int exp_grant;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int toggles = 0;
  int onehot_bad = 0;
  int glen = 0;
  int ack_cyc = -10;
  wr_t exp_q[$];
  int  exp_grants[$];
  logic [NR-1:0] en_prev = '0;
  logic prev_ras = 1'b0;
  logic prev_busy = 1'b0;

  int rem[NR], cnt[NR], brow[NR], bcol[NR], bdata[NR], rel_cyc[NR], glen_ack[NR];
  bit hang[NR], early[NR];
  bit [NR-1:0] ack_seen = '0;
  logic [7:0] last_data[NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    wr_t e;
    if (ram_access_start !== prev_ras) begin
      prev_ras = ram_access_start;
      toggles++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_toggle: got a strobe toggle expected none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("fwd_write", 32'({row, column, pixel, data_out}), 32'(e));
        check("fwd_we", 32'(ram_write_enable), 32'd1);
      end
    end
    if (busy && !prev_busy) begin
      glen = 1;
      if (exp_grants.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got grant %0d expected none", grant_id);
      end else begin
        check("grant_order", 32'(grant_id), 32'(exp_grants.pop_front()));
      end
    end else if (busy && eng_ack == '0) begin
      glen++;
    end
    for (int i = 0; i < NR; i++) begin
      if (eng_ack[i]) begin
        ack_seen[i] = 1'b1;
        glen_ack[i] = glen;
        ack_cyc = cyc;
        if (rel_cyc[i] >= 0) check("ack_latency", 32'(cyc), 32'(rel_cyc[i] + 1));
      end
    end
    if (!busy && prev_busy) check("busy_drop", 32'(cyc), 32'(ack_cyc + 1));
    prev_busy = busy;
  endtask

  // Engine models: advance one byte per enabled cycle, then present done with we low.
  task automatic engines();
    wr_t w;
    for (int i = 0; i < NR; i++) begin
      if (eng_ack[i]) begin
        req[i] = 1'b0;
        eng_done[i] = 1'b0;
        eng_we[i] = 1'b0;
      end else if (req[i] && en_prev[i] && !hang[i]) begin
        if (rem[i] > 0) begin
          w.row  = 5'(brow[i]);
          w.col  = 6'(bcol[i] + cnt[i] / 2);
          w.pix  = 1'(cnt[i] % 2);
          w.data = 8'(bdata[i] + cnt[i]);
          eng_row[i*RW +: RW]     = w.row;
          eng_column[i*CW +: CW]  = w.col;
          eng_pixel[i*PSW +: PSW] = w.pix;
          eng_data[i*8 +: 8]      = w.data;
          eng_we[i] = 1'b1;
          eng_strobe[i] = ~eng_strobe[i];
          exp_q.push_back(w);
          last_data[i] = w.data;
          cnt[i]++;
          rem[i]--;
          if (rem[i] == 0 && early[i]) eng_done[i] = 1'b1;
        end else begin
          eng_we[i] = 1'b0;
          eng_done[i] = 1'b1;
          if (rel_cyc[i] < 0) rel_cyc[i] = cyc;
        end
      end
    end
  endtask

  task automatic cycle(input logic mr);
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    engines();
    mem_ready = mr;
    #1;
    en_prev = eng_enable;
    if ($countones(eng_enable) > 1 || $countones(eng_ack) > 1) onehot_bad++;
  endtask

  task automatic start_cmd(input int id, input int n, input int r, input int c,
                           input int d, input bit e);
    rem[id] = n;
    cnt[id] = 0;
    brow[id] = r;
    bcol[id] = c;
    bdata[id] = d;
    early[id] = e;
    hang[id] = 1'b0;
    rel_cyc[id] = -1;
    ack_seen[id] = 1'b0;
    eng_done[id] = 1'b0;
    eng_we[id] = 1'b0;
    req[id] = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while ((req != '0 || busy) && k < budget) begin
      cycle(1'b1);
      k++;
    end
    check(name, 32'(k < budget), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    int t0, t1, k;
    bit restarted;

    vecs[0] = '{id: 0, nbytes: 4, r: 3,  c: 10, d: 'h10, early: 0, exp_grant: 0};
    vecs[1] = '{id: 2, nbytes: 1, r: 31, c: 63, d: 'hFE, early: 0, exp_grant: 2};
    vecs[2] = '{id: 1, nbytes: 3, r: 0,  c: 0,  d: 'hA0, early: 1, exp_grant: 1};
    vecs[3] = '{id: 0, nbytes: 0, r: 1,  c: 1,  d: 'h00, early: 0, exp_grant: 0};
    vecs[4] = '{id: 1, nbytes: 2, r: 7,  c: 20, d: 'h55, early: 1, exp_grant: 1};

    req = '0; mem_ready = 1'b1;
    eng_row = '0; eng_column = '0; eng_pixel = '0; eng_data = '0;
    eng_we = '0; eng_done = '0;
    eng_strobe = 3'b010;   // engine 1 idles with strobe high
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; cnt[i] = 0; rel_cyc[i] = -1; hang[i] = 0; early[i] = 0;
      glen_ack[i] = 0; last_data[i] = '0;
    end

    reset = 1'b0;
    #3 reset = 1'b1;
    #20;
    check("reset_outputs", {eng_enable, eng_ack, row, column, pixel, data_out,
          ram_write_enable, ram_access_start, busy, grant_id, timeout_err}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Contention from reset: order 0,1,2 then engine 0 again.
    start_cmd(0, 2, 1, 1, 'h20, 0);
    start_cmd(1, 2, 2, 2, 'h30, 0);
    start_cmd(2, 2, 3, 3, 'h40, 0);
    exp_grants.push_back(0); exp_grants.push_back(1);
    exp_grants.push_back(2); exp_grants.push_back(0);
    restarted = 0;
    k = 0;
    while ((req != '0 || busy || !restarted) && k < 300) begin
      cycle(1'b1);
      k++;
      if (ack_seen[0] && !restarted) begin
        restarted = 1;
        start_cmd(0, 1, 4, 4, 'h50, 0);
      end
    end
    check("contention_done", 32'(k < 300), 32'd1);
    check("contention_grants_left", 32'(exp_grants.size()), 32'd0);

    // Table-driven single commands.
    foreach (vecs[v]) begin
      t0 = toggles;
      start_cmd(vecs[v].id, vecs[v].nbytes, vecs[v].r, vecs[v].c, vecs[v].d, vecs[v].early);
      exp_grants.push_back(vecs[v].exp_grant);
      wait_idle(100, "vec_idle");
      check("vec_toggles", 32'(toggles - t0), 32'(vecs[v].nbytes));
      check("vec_ack", 32'(ack_seen[vecs[v].id]), 32'd1);
      check("vec_no_timeout", 32'(timeout_err), 32'd0);
    end

    // Backpressure: 5 stalled cycles in the middle of a 6-byte command.
    t0 = toggles;
    start_cmd(0, 6, 10, 30, 'h80, 0);
    exp_grants.push_back(0);
    k = 0;
    while (toggles - t0 < 2 && k < 50) begin cycle(1'b1); k++; end
    check("bp_start", 32'(k < 50), 32'd1);
    t1 = toggles;
    for (int s = 0; s < 5; s++) begin
      cycle(1'b0);
      check("stall_enable", 32'(eng_enable), 32'd0);
      if (s == 1) t1 = toggles;
      if (s >= 1) check("stall_hold", 32'({ram_write_enable, data_out}), 32'({1'b1, last_data[0]}));
    end
    check("stall_no_toggle", 32'(toggles - t1), 32'd0);
    wait_idle(100, "bp_idle");
    check("bp_toggles", 32'(toggles - t0), 32'd6);

    // Watchdog: engine 1 hangs, engine 2 waits behind it.
    start_cmd(1, 0, 0, 0, 0, 0);
    hang[1] = 1'b1;
    start_cmd(2, 1, 5, 5, 'h66, 0);
    exp_grants.push_back(1); exp_grants.push_back(2);
    wait_idle(200, "wd_idle");
    check("wd_grant_len", 32'(glen_ack[1]), 32'd16);
    check("wd_timeout_err", 32'(timeout_err), 32'd1);
    check("wd_next_acked", 32'(ack_seen[2]), 32'd1);
    hang[1] = 1'b0;

    // Reset mid-grant: leave rr_ptr at 1, then abort engine 2 after 3 bytes.
    start_cmd(0, 1, 2, 2, 'h11, 0);
    exp_grants.push_back(0);
    wait_idle(100, "pre_reset_idle");
    t0 = toggles;
    start_cmd(2, 6, 8, 8, 'h90, 0);
    exp_grants.push_back(2);
    k = 0;
    while (toggles - t0 < 3 && k < 50) begin cycle(1'b1); k++; end
    check("rst_start", 32'(k < 50), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_grant", {eng_enable, eng_ack, row, column, pixel, data_out,
          ram_write_enable, ram_access_start, busy, grant_id, timeout_err}, 32'd0);
    req = '0; eng_we = '0; eng_done = '0; eng_strobe = '0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    exp_q.delete();
    exp_grants.delete();
    prev_ras = 1'b0; prev_busy = 1'b0; en_prev = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    start_cmd(0, 1, 1, 2, 'hC0, 0);
    start_cmd(1, 1, 3, 4, 'hC1, 0);
    start_cmd(2, 1, 5, 6, 'hC2, 0);
    exp_grants.push_back(0); exp_grants.push_back(1); exp_grants.push_back(2);
    wait_idle(200, "post_reset_idle");

    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("grants_left", 32'(exp_grants.size()), 32'd0);
    check("onehot_enable_ack", 32'(onehot_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
